// File: rtl/div_ctrl.sv
// div_ctrl: sequencer for a restoring shift-subtract divider driving the A/Q register strobes
module div_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] divisor,
  input  logic         diff_neg,
  output logic         load,
  output logic         shift,
  output logic         hab_A,
  output logic         set_Q0,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero
);
  localparam int CW = $clog2(N + 1);
  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, TEST, WRA, SETQ, DONE} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic dbz_n, zero, last;
  assign zero = divisor == '0;
  assign last = cnt == CW'(1);
  // state, iteration counter and error flag registers; rst is active-low
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      div_by_zero <= dbz_n;
    end
  end
  // next state, counter update and error flag capture at start acceptance
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    dbz_n = div_by_zero;
    case (state)
      IDLE: if (start) begin
        dbz_n = zero;
        state_n = zero ? DONE : LOAD;
        cnt_n = zero ? cnt : CW'(N);
      end
      LOAD: state_n = SHIFT;
      SHIFT: state_n = TEST;
      TEST: if (diff_neg) begin
        cnt_n = cnt - CW'(1);
        state_n = last ? DONE : SHIFT;
      end else state_n = WRA;
      WRA: state_n = SETQ;
      SETQ: begin
        cnt_n = cnt - CW'(1);
        state_n = last ? DONE : SHIFT;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign load = state == LOAD;
  assign shift = state == SHIFT;
  assign hab_A = state == WRA;
  assign set_Q0 = state == SETQ;
  assign done = state == DONE;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed checks of the divider sequencer against a behavioural A/Q datapath
module tb_div_ctrl;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0;
  logic diff_neg, load, shift, hab_A, set_Q0, busy, done, div_by_zero, dbz1;
  logic [N-1:0] divisor = '0, dividend = '0, q = '0;
  logic [N:0] a = '0, diff;
  int mode = 0, total = 0, bad = 0;
  int done_cyc, n_load, n_shift, n_hab, n_setq;
  int trace [1:40];
  int exp7 [1:13];

  always #5 clk = ~clk;

  div_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst), .start(start), .divisor(divisor), .diff_neg(diff_neg),
    .load(load), .shift(shift), .hab_A(hab_A), .set_Q0(set_Q0),
    .busy(busy), .done(done), .div_by_zero(div_by_zero)
  );

  // behavioural A/Q register obeying the strobes
  always @(posedge clk) begin
    if (load) begin
      a <= '0;
      q <= dividend;
    end else if (shift) {a, q} <= {a[N-1:0], q, 1'b0};
    else if (hab_A) a <= a - {1'b0, divisor};
    else if (set_Q0) q[0] <= 1'b1;
  end
  assign diff = a - {1'b0, divisor};
  assign diff_neg = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : diff[N];

  task automatic run(input logic [N-1:0] dd, input logic [N-1:0] mm, input int md, input int p0, input int p1);
    @(negedge clk);
    dividend = dd; divisor = mm; mode = md; start = 1'b1;
    done_cyc = 0; n_load = 0; n_shift = 0; n_hab = 0; n_setq = 0;
    @(negedge clk);
    dbz1 = div_by_zero;
    for (int c = 1; c <= 40; c++) begin
      trace[c] = load ? 1 : shift ? 2 : hab_A ? 3 : set_Q0 ? 4 : 0;
      if (load) n_load++;
      if (shift) n_shift++;
      if (hab_A) n_hab++;
      if (set_Q0) n_setq++;
      start = (c >= p0 && c <= p1);
      if (done) begin
        done_cyc = c;
        start = 1'b0;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({load, shift, hab_A, set_Q0, busy, done, div_by_zero} !== 7'b0) begin
      bad++; $display("FAIL reset_outputs got=%b want=0000000", {load, shift, hab_A, set_Q0, busy, done, div_by_zero});
    end
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({load, shift, hab_A, set_Q0, busy, done} !== 6'b0) begin
        bad++; $display("FAIL reset_start_ignored cyc=%0d got=%b want=000000", i, {load, shift, hab_A, set_Q0, busy, done});
      end
    end
    start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++; $display("FAIL idle_busy got=%b want=0", busy);
    end
  endtask

  task automatic test_divide;
    run(4'd7, 4'd2, 0, 0, -1);
    for (int i = 1; i <= 13; i++) begin
      total++;
      if (trace[i] !== exp7[i]) begin
        bad++; $display("FAIL seq7_cyc%0d got=%0d want=%0d", i, trace[i], exp7[i]);
      end
    end
    total++;
    if (done_cyc !== 14) begin bad++; $display("FAIL done7_cycle got=%0d want=14", done_cyc); end
    total++;
    if (q !== 4'd3) begin bad++; $display("FAIL quotient got=%0d want=3", q); end
    total++;
    if (a !== 5'd1) begin bad++; $display("FAIL remainder got=%0d want=1", a); end
  endtask

  task automatic test_zero_divisor;
    run(4'd5, 4'd0, 0, 0, -1);
    total++;
    if (done_cyc !== 1) begin bad++; $display("FAIL dbz_done_cycle got=%0d want=1", done_cyc); end
    total++;
    if (n_load + n_shift !== 0) begin bad++; $display("FAIL dbz_strobes got=%0d want=0", n_load + n_shift); end
    total++;
    if (dbz1 !== 1'b1) begin bad++; $display("FAIL dbz_flag got=%b want=1", dbz1); end
    @(negedge clk);
    total++;
    if ({div_by_zero, busy} !== 2'b10) begin bad++; $display("FAIL dbz_hold got=%b want=10", {div_by_zero, busy}); end
    run(4'd7, 4'd2, 0, 0, -1);
    total++;
    if (dbz1 !== 1'b0) begin bad++; $display("FAIL dbz_clear got=%b want=0", dbz1); end
    total++;
    if (done_cyc !== 14) begin bad++; $display("FAIL dbz_next_done got=%0d want=14", done_cyc); end
  endtask

  task automatic test_forced;
    run(4'd9, 4'd3, 1, 0, -1);
    total++;
    if ({n_shift, n_hab, done_cyc} !== {32'd4, 32'd0, 32'd10}) begin
      bad++; $display("FAIL all_neg got=shift%0d/hab%0d/done%0d want=shift4/hab0/done10", n_shift, n_hab, done_cyc);
    end
    run(4'd9, 4'd3, 2, 0, -1);
    total++;
    if ({n_shift, n_hab, n_setq, done_cyc} !== {32'd4, 32'd4, 32'd4, 32'd18}) begin
      bad++; $display("FAIL all_pos got=shift%0d/hab%0d/setq%0d/done%0d want=4/4/4/18", n_shift, n_hab, n_setq, done_cyc);
    end
  endtask

  task automatic test_start_ignored;
    run(4'd7, 4'd2, 0, 2, 12);
    for (int i = 1; i <= 13; i++) begin
      total++;
      if (trace[i] !== exp7[i]) begin
        bad++; $display("FAIL busy_start_cyc%0d got=%0d want=%0d", i, trace[i], exp7[i]);
      end
    end
    total++;
    if ({n_load, done_cyc} !== {32'd1, 32'd14}) begin
      bad++; $display("FAIL busy_start_done got=load%0d/done%0d want=load1/done14", n_load, done_cyc);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    divisor = 4'd0; start = 1'b1;
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL b2b_first got=%b want=1", done); end
    @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin bad++; $display("FAIL b2b_idle got=%b want=00", {busy, done}); end
    @(negedge clk);
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL b2b_second got=%b want=1", done); end
    start = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    @(negedge clk);
    dividend = 4'd7; divisor = 4'd2; mode = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (hab_A !== 1'b1) begin bad++; $display("FAIL mid_in_wra got=%b want=1", hab_A); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({load, shift, hab_A, set_Q0, busy, done, div_by_zero} !== 7'b0) begin
      bad++; $display("FAIL mid_reset got=%b want=0000000", {load, shift, hab_A, set_Q0, busy, done, div_by_zero});
    end
    rst = 1'b1;
    run(4'd7, 4'd2, 0, 0, -1);
    total++;
    if ({done_cyc, 28'd0, q, 27'd0, a} !== {32'd14, 28'd0, 4'd3, 27'd0, 5'd1}) begin
      bad++; $display("FAIL mid_rerun got=done%0d/q%0d/a%0d want=done14/q3/a1", done_cyc, q, a);
    end
  endtask

  initial begin
    exp7 = '{1, 2, 0, 2, 0, 2, 0, 3, 4, 2, 0, 3, 4};
    test_reset;
    test_divide;
    test_zero_divisor;
    test_forced;
    test_start_ignored;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
